// File: rtl/addsub_acc.sv
// Registered add/subtract unit with an accumulator, optional signed saturation,
// sticky overflow flags and a single-entry valid/ready output stage.
module addsub_acc #(
    parameter int WIDTH  = 8,
    parameter bit SAT_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       mode,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] s,
    output logic             ovu,
    output logic             ovs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             stku,
    output logic             stks
);

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             accept;
    logic             use_acc;
    logic             sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_b_inv;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] raw;
    logic             carry_out;
    logic             carry_msb;
    logic             ovu_c;
    logic             ovs_c;
    logic [WIDTH-1:0] res;

    // The output stage can take a new result whenever it is empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign use_acc  = mode[1];
    assign sub      = mode[0];

    // A clear arriving with an accumulate operation makes the accumulator read as zero.
    assign op_a     = use_acc ? (clr ? '0 : acc) : x;
    assign op_b     = use_acc ? x : y;
    assign op_b_inv = op_b ^ {WIDTH{sub}};

    assign sum       = {1'b0, op_a} + {1'b0, op_b_inv} + {{WIDTH{1'b0}}, sub};
    assign raw       = sum[WIDTH-1:0];
    assign carry_out = sum[WIDTH];
    assign carry_msb = op_a[WIDTH-1] ^ op_b_inv[WIDTH-1] ^ raw[WIDTH-1];
    assign ovs_c     = carry_msb ^ carry_out;
    assign ovu_c     = carry_out ^ sub;

    // NOTE: res gets a default before the conditional so no latch is inferred.
    always_comb begin
        res = raw;
        if (SAT_EN && ovs_c) begin
            res = op_a[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            ovu       <= 1'b0;
            ovs       <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            s         <= res;
            ovu       <= ovu_c;
            ovs       <= ovs_c;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept && use_acc) begin
            acc <= res;
        end else if (clr) begin
            acc <= '0;
        end
    end

    // On clear-with-accept the sticky flags restart from this operation alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stku <= 1'b0;
            stks <= 1'b0;
        end else if (accept) begin
            stku <= (stku && !clr) || ovu_c;
            stks <= (stks && !clr) || ovs_c;
        end else if (clr) begin
            stku <= 1'b0;
            stks <= 1'b0;
        end
    end

endmodule
